// File: rtl/sbox_sched_pkg.sv
// Shared types and constants for the time-multiplexed AES S-box scheduler.
// Holds FSM encoding, beat count and word/byte slicing helpers.
package sbox_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int NBEATS  = 4;
    localparam int STATE_W = 128;
    localparam int WORD_W  = 32;
    localparam int BYTE_W  = 8;
    localparam int NBYTES  = WORD_W / BYTE_W;

    // Word 0 is the most significant word of the state (bytes 15..12).
    function automatic int word_msb(input logic [1:0] k);
        return STATE_W - 1 - WORD_W * int'(k);
    endfunction

    function automatic logic [WORD_W-1:0] state_word(
        input logic [STATE_W-1:0] s,
        input logic [1:0]         k
    );
        return s[word_msb(k) -: WORD_W];
    endfunction

endpackage

// File: rtl/sbox_sched_if.sv
// Handshake bundle between the scheduler and its two requesters.
// slave = scheduler side, master = round controller / key expansion side.
interface sbox_sched_if;
    import sbox_sched_pkg::*;

    logic                 st_valid;
    logic                 st_ready;
    logic [STATE_W-1:0]   st_data;
    logic                 st_out_valid;
    logic                 st_out_ready;
    logic [STATE_W-1:0]   st_out_data;
    logic                 kw_req;
    logic [WORD_W-1:0]    kw_word;
    logic                 kw_ack;
    logic [WORD_W-1:0]    kw_result;
    logic                 busy;

    modport slave (
        input  st_valid, st_data, st_out_ready,
        input  kw_req, kw_word,
        output st_ready, st_out_valid, st_out_data,
        output kw_ack, kw_result, busy
    );

    modport master (
        output st_valid, st_data, st_out_ready,
        output kw_req, kw_word,
        input  st_ready, st_out_valid, st_out_data,
        input  kw_ack, kw_result, busy
    );

endinterface

// File: rtl/sbox_sched_word.sv
// Four AES S-box lookups side by side, purely combinational.
// Each byte is inverted in GF(2^8) as x^254, then the affine map is applied.
module sbox_word
    import sbox_sched_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    output logic [WORD_W-1:0] o_word
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        logic [7:0] v;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        x252 = gmul(x240, x12);
        v    = gmul(x252, x2);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
                 ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    for (genvar g = 0; g < NBYTES; g++) begin : g_byte
        assign o_word[g*BYTE_W +: BYTE_W] =
            sbox_byte(i_word[g*BYTE_W +: BYTE_W]);
    end

endmodule

// File: rtl/sbox_sched.sv
// Shares one 4-byte S-box word between SubBytes beats and SubWord requests.
// A 128-bit state is substituted one word per cycle; key requests steal slots.
module sbox_sched
    import sbox_sched_pkg::*;
#(
    parameter bit KEY_PRIO = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    sbox_sched_if.slave bus
);

    state_e             r_state;
    logic [1:0]         r_k;
    logic [STATE_W-1:0] r_work;
    logic [STATE_W-1:0] r_out;
    logic               r_out_valid;
    logic               r_ack;
    logic [WORD_W-1:0]  r_res;
    logic               r_busy;

    logic               w_grant;
    logic [WORD_W-1:0]  w_lut_in;
    logic [WORD_W-1:0]  w_lut_out;

    // r_ack blocks re-serving a request still held during its ack cycle.
    assign w_grant  = bus.kw_req && !r_ack
                    && (KEY_PRIO || (r_state != S_RUN));
    assign w_lut_in = w_grant ? bus.kw_word : state_word(r_work, r_k);

    sbox_word u_sbox (
        .i_word (w_lut_in),
        .o_word (w_lut_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_k         <= 2'd0;
            r_work      <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_ack       <= 1'b0;
            r_res       <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_ack <= w_grant;
            if (w_grant) r_res <= w_lut_out;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.st_valid) begin
                        r_work  <= bus.st_data;
                        r_k     <= 2'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!w_grant) begin
                        r_out[word_msb(r_k) -: WORD_W] <= w_lut_out;
                        r_k <= r_k + 2'd1;
                        if (r_k == 2'(NBEATS - 1)) begin
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.st_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.st_ready     = (r_state == S_IDLE);
    assign bus.st_out_valid = r_out_valid;
    assign bus.st_out_data  = r_out;
    assign bus.kw_ack       = r_ack;
    assign bus.kw_result    = r_res;
    assign bus.busy         = r_busy;

endmodule

// File: tb/tb_sbox_sched.sv
// Directed bench for sbox_sched: KEY_PRIO=1 and KEY_PRIO=0 instances side by side.
// Expected results are queued at stimulus time and popped when each DUT answers.
module tb_sbox_sched;

    logic         clk;
    logic         rst_n;
    logic         st_valid;
    logic [127:0] st_data;
    logic         st_out_ready;
    logic         kw_req1;
    logic         kw_req0;
    logic [31:0]  kw_word;

    int n_cmp;
    int n_err;
    int cyc;
    int ack1_cyc;
    int ack0_cyc;
    int t0;

    logic [127:0] q_st1[$];
    logic [127:0] q_st0[$];
    logic [31:0]  q_kw1[$];
    logic [31:0]  q_kw0[$];

    localparam logic [127:0] VEC_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] VEC_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] ZERO_OUT = {16{8'h63}};

    sbox_sched_if bus1();
    sbox_sched_if bus0();

    assign bus1.st_valid     = st_valid;
    assign bus1.st_data      = st_data;
    assign bus1.st_out_ready = st_out_ready;
    assign bus1.kw_req       = kw_req1;
    assign bus1.kw_word      = kw_word;
    assign bus0.st_valid     = st_valid;
    assign bus0.st_data      = st_data;
    assign bus0.st_out_ready = st_out_ready;
    assign bus0.kw_req       = kw_req0;
    assign bus0.kw_word      = kw_word;

    sbox_sched #(.KEY_PRIO(1'b1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    sbox_sched #(.KEY_PRIO(1'b0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_out_valid_p1", 128'(bus1.st_out_valid), 128'd0);
        chk("rst_out_data_p1", bus1.st_out_data, 128'd0);
        chk("rst_kw_ack_p1", 128'(bus1.kw_ack), 128'd0);
        chk("rst_kw_result_p1", 128'(bus1.kw_result), 128'd0);
        chk("rst_busy_p1", 128'(bus1.busy), 128'd0);
        chk("rst_st_ready_p1", 128'(bus1.st_ready), 128'd1);
        chk("rst_out_valid_p0", 128'(bus0.st_out_valid), 128'd0);
        chk("rst_out_data_p0", bus0.st_out_data, 128'd0);
        chk("rst_kw_ack_p0", 128'(bus0.kw_ack), 128'd0);
        chk("rst_kw_result_p0", 128'(bus0.kw_result), 128'd0);
        chk("rst_busy_p0", 128'(bus0.busy), 128'd0);
        chk("rst_st_ready_p0", 128'(bus0.st_ready), 128'd1);
    endtask

    // One clock; the key requester side reacts to kw_ack here.
    task automatic step();
        logic [31:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (bus1.kw_ack) begin
            kw_req1  = 1'b0;
            ack1_cyc = cyc;
            chk("kw_ack_expected_p1", 128'(bus1.kw_ack), 128'(q_kw1.size() != 0));
            if (q_kw1.size() != 0) begin
                e = q_kw1.pop_front();
                chk("kw_result_p1", 128'(bus1.kw_result), 128'(e));
            end
        end
        if (bus0.kw_ack) begin
            kw_req0  = 1'b0;
            ack0_cyc = cyc;
            chk("kw_ack_expected_p0", 128'(bus0.kw_ack), 128'(q_kw0.size() != 0));
            if (q_kw0.size() != 0) begin
                e = q_kw0.pop_front();
                chk("kw_result_p0", 128'(bus0.kw_result), 128'(e));
            end
        end
    endtask

    task automatic accept(input logic [127:0] d, input logic [127:0] e);
        st_valid = 1'b1;
        st_data  = d;
        step();
        st_valid = 1'b0;
        t0 = cyc;
        q_st1.push_back(e);
        q_st0.push_back(e);
        chk("acc_busy_p1", 128'(bus1.busy), 128'd1);
        chk("acc_st_ready_p1", 128'(bus1.st_ready), 128'd0);
        chk("acc_busy_p0", 128'(bus0.busy), 128'd1);
        chk("acc_st_ready_p0", 128'(bus0.st_ready), 128'd0);
    endtask

    task automatic key_req(input logic [31:0] w, input logic [31:0] e);
        kw_word = w;
        kw_req1 = 1'b1;
        kw_req0 = 1'b1;
        q_kw1.push_back(e);
        q_kw0.push_back(e);
    endtask

    task automatic wait_out(input int exp1, input int exp0);
        int lat1;
        int lat0;
        int n;
        logic [127:0] e;
        lat1 = -1;
        lat0 = -1;
        n = 0;
        while ((lat1 < 0 || lat0 < 0 || q_kw1.size() != 0
                || q_kw0.size() != 0) && n < 24) begin
            step();
            n++;
            if (bus1.st_out_valid && lat1 < 0) lat1 = cyc - t0;
            if (bus0.st_out_valid && lat0 < 0) lat0 = cyc - t0;
        end
        chk("latency_p1", 128'(lat1), 128'(exp1));
        chk("latency_p0", 128'(lat0), 128'(exp0));
        chk("kw_drained_p1", 128'(q_kw1.size()), 128'd0);
        chk("kw_drained_p0", 128'(q_kw0.size()), 128'd0);
        if (lat1 >= 0 && q_st1.size() != 0) begin
            e = q_st1.pop_front();
            chk("st_out_data_p1", bus1.st_out_data, e);
        end
        if (lat0 >= 0 && q_st0.size() != 0) begin
            e = q_st0.pop_front();
            chk("st_out_data_p0", bus0.st_out_data, e);
        end
    endtask

    task automatic take();
        st_out_ready = 1'b1;
        step();
        st_out_ready = 1'b0;
        chk("take_valid_p1", 128'(bus1.st_out_valid), 128'd0);
        chk("take_ready_p1", 128'(bus1.st_ready), 128'd1);
        chk("take_busy_p1", 128'(bus1.busy), 128'd0);
        chk("take_valid_p0", 128'(bus0.st_out_valid), 128'd0);
        chk("take_ready_p0", 128'(bus0.st_ready), 128'd1);
        chk("take_busy_p0", 128'(bus0.busy), 128'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        ack1_cyc = -1;
        ack0_cyc = -1;
        t0 = 0;
        rst_n = 1'b0;
        st_valid = 1'b0;
        st_data = '0;
        st_out_ready = 1'b0;
        kw_req1 = 1'b0;
        kw_req0 = 1'b0;
        kw_word = '0;

        #12;
        chk_reset_vals();
        rst_n = 1'b1;
        step();

        // State only
        accept(VEC_IN, VEC_OUT);
        wait_out(4, 4);
        take();

        // Key only while idle
        key_req(32'hcf4f3c09, 32'h8a84eb01);
        t0 = cyc;
        step();
        chk("idle_ack_lat_p1", 128'(ack1_cyc - t0), 128'd1);
        chk("idle_ack_lat_p0", 128'(ack0_cyc - t0), 128'd1);
        chk("idle_key_ready_p1", 128'(bus1.st_ready), 128'd1);
        chk("idle_key_busy_p0", 128'(bus0.busy), 128'd0);
        step();
        chk("ack_pulse_p1", 128'(bus1.kw_ack), 128'd0);
        chk("ack_pulse_p0", 128'(bus0.kw_ack), 128'd0);
        key_req(32'h0153ff00, 32'h7ced1663);
        t0 = cyc;
        step();
        chk("idle_ack2_lat_p1", 128'(ack1_cyc - t0), 128'd1);
        step();

        // Contention: key raised on beat 1
        accept(VEC_IN, VEC_OUT);
        step();
        key_req(32'hcf4f3c09, 32'h8a84eb01);
        wait_out(5, 4);
        chk("cont_ack_at_p1", 128'(ack1_cyc - t0), 128'd2);
        chk("cont_ack_at_p0", 128'(ack0_cyc - t0), 128'd5);
        take();

        // Backpressure, then a state offered in DONE must not be taken
        accept(VEC_IN, VEC_OUT);
        wait_out(4, 4);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid_p1", 128'(bus1.st_out_valid), 128'd1);
            chk("bp_data_p1", bus1.st_out_data, VEC_OUT);
            chk("bp_ready_p1", 128'(bus1.st_ready), 128'd0);
            chk("bp_data_p0", bus0.st_out_data, VEC_OUT);
        end
        st_valid = 1'b1;
        st_data = '0;
        take();
        st_valid = 1'b0;
        step();
        chk("no_reaccept_p1", 128'(bus1.busy), 128'd0);
        chk("no_reaccept_p0", 128'(bus0.st_ready), 128'd1);

        // Reset on beat 2 with a key request outstanding
        accept(VEC_IN, VEC_OUT);
        step();
        step();
        kw_word = 32'hcf4f3c09;
        kw_req1 = 1'b1;
        kw_req0 = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        kw_req1 = 1'b0;
        kw_req0 = 1'b0;
        q_st1.delete();
        q_st0.delete();
        q_kw1.delete();
        q_kw0.delete();
        chk_reset_vals();
        step();
        chk_reset_vals();
        rst_n = 1'b1;
        step();
        accept('0, ZERO_OUT);
        wait_out(4, 4);
        take();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sbox_sched.md
# sbox_sched

Time-multiplexed scheduler for a shared bank of four AES S-box lookups. It accepts a 128-bit state for SubBytes and processes it one 32-bit word per cycle. It also serves 32-bit SubWord requests from key expansion on the same lookups and arbitrates between the two requesters. It sits between the round controller, the key-expansion unit and the S-box datapath, replacing sixteen parallel lookups with four.

## Interface
Parameters:
- KEY_PRIO, default 1: 1 = key requests pre-empt state beats; 0 = key requests served only while no state beat is pending.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- st_valid  input  1  state request valid.
- st_ready  output  1  scheduler can accept a state; high only in IDLE.
- st_data  input  128  state to substitute; byte 15 = bits [127:120].
- st_out_valid  output  1  substituted state valid; held until taken.
- st_out_ready  input  1  consumer accepts st_out_data.
- st_out_data  output  128  SubBytes(st_data), same byte order.
- kw_req  input  1  key-expansion SubWord request; level, held until kw_ack.
- kw_word  input  32  word to substitute; stable while kw_req is high.
- kw_ack  output  1  one-cycle pulse; kw_result valid in the same cycle.
- kw_result  output  32  SubWord(kw_word), registered.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: on st_valid && st_ready, capture st_data into the working register, clear beat counter (2 bits), go to RUN.
- RUN:
  - Each cycle the lookups serve either the key word or state word k = bits [127-32k -: 32].
  - A state beat writes its 4 results into the same slot of the output register and increments k.
  - After the beat with k = 3, go to DONE.
- DONE: st_out_valid = 1. On st_out_ready, go to IDLE. The state is not re-accepted in the same cycle.
- Key grant: kw_req && !kw_ack && (KEY_PRIO || state != RUN).
  - The !kw_ack term prevents double service of a held request.
  - A granted cycle in RUN stalls the state beat; k does not advance.
  - A continuously re-asserted kw_req with KEY_PRIO=1 therefore gets at most every other cycle, so state progress is guaranteed.
- Key grant in IDLE or DONE does not disturb the FSM or st_out_data.
- Simultaneous st_valid and kw_req in IDLE: both are accepted. The key is served this cycle, and the state capture proceeds normally since capture does not use the lookups.
- Reset mid-operation: the FSM returns to IDLE, partial results are discarded, and any pending kw_ack is suppressed.
- Reset values:
  - st_out_valid = 0, st_out_data = 0, kw_ack = 0, kw_result = 0, busy = 0.
  - st_ready = 1 (combinational from IDLE).

## Timing
- State latency with no key contention:
  - Accept at edge T.
  - Beats registered at edges T+1..T+4.
  - st_out_valid high from edge T+4.
  - Each granted key cycle in RUN adds one cycle.
- Minimum state-to-state spacing: 6 cycles (accept, 4 beats, DONE handshake, IDLE).
- Key latency: grant cycle at edge G; kw_ack and kw_result valid after edge G+1 for exactly one cycle.
- The requester drops or changes kw_req/kw_word in the kw_ack cycle; a new request is granted no earlier than the cycle after kw_ack.
- With KEY_PRIO=0 and a request arriving in RUN, the grant occurs in the DONE cycle at the latest.
- All outputs are registered except st_ready.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE/RUN/DONE).
  - Beat count constant NBEATS = 4.
  - Byte-order helper constants for word/byte slicing.
- Sub-module sbox_word: four byte S-box lookups side by side (32-bit in, 32-bit out), purely combinational.
- sbox_sched instantiates one sbox_word behind a 2:1 input mux driven by the key grant.

## Test plan
- State only: st_data = 00112233445566778899aabbccddeeff -> st_out_data = 638293c31bfc33f5c4eeacea4bc12816, st_out_valid exactly 4 cycles after accept.
- Key only, idle: kw_word = cf4f3c09 -> kw_ack one cycle after the request, kw_result = 8a84eb01; FSM stays IDLE.
- Contention, KEY_PRIO=1: kw_req raised on beat 1 of the vector above -> kw_result = 8a84eb01, state latency 5 cycles, same state result.
- Contention, KEY_PRIO=0: same stimulus -> kw_ack after the DONE-cycle grant, state latency 4 cycles.
- Backpressure: hold st_out_ready = 0 for 10 cycles -> st_out_valid and data stable, st_ready = 0; release -> IDLE next cycle.
- Reset on beat 2 -> all outputs at reset values, st_ready = 1; the next state 00…00 yields 6363…63.
